// File: rtl/ascon_init_core.sv
// ascon_init_core: ASCON p^a initialisation engine, UNROLL rounds per clock,
// final key XOR folded into the last round write, start/busy/end handshake.
module ascon_init_core #(
  parameter int RATE_BITS = 64,
  parameter int ROUNDS_A  = 12,
  parameter int ROUNDS_B  = 6,
  parameter int UNROLL    = 1
) (
  input  logic         clock_i,
  input  logic         resetb_i,
  input  logic         start_i,
  input  logic [127:0] key_i,
  input  logic [127:0] nonce_i,
  output logic         busy_o,
  output logic         end_o,
  output logic [3:0]   round_o,
  output logic [319:0] state_o
);
  if (RATE_BITS != 64 && RATE_BITS != 128) begin : g_bad_rate
    $error("ascon_init_core: RATE_BITS must be 64 or 128");
  end
  if (ROUNDS_A < 1 || ROUNDS_A > 12 || ROUNDS_B < 1 || ROUNDS_B > 12) begin : g_bad_rounds
    $error("ascon_init_core: ROUNDS_A and ROUNDS_B must be in 1..12");
  end
  if (UNROLL < 1 || (ROUNDS_A % UNROLL) != 0) begin : g_bad_unroll
    $error("ascon_init_core: UNROLL must divide ROUNDS_A");
  end
  localparam logic [63:0] IV     = {8'd128, 8'(RATE_BITS), 8'(ROUNDS_A), 8'(ROUNDS_B), 32'h0};
  localparam logic [3:0]  J0     = 4'(12 - ROUNDS_A);
  localparam logic [3:0]  J_LAST = 4'(12 - UNROLL);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t         r_fsm, w_fsm_next;
  logic [3:0]     r_j, w_j_next;
  logic [4:0]     w_j_sum;
  logic [127:0]   r_key;
  logic [319:0]   r_s, w_next;
  logic           w_last;
  function automatic logic [63:0] ror(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction
  // One full ASCON round: constant addition, bitsliced S-box, linear diffusion.
  function automatic logic [319:0] round_f(input logic [319:0] s, input logic [3:0] j);
    logic [63:0] x0, x1, x2, x3, x4;
    logic [63:0] t0, t1, t2, t3, t4;
    {x0, x1, x2, x3, x4} = s;
    x2 = x2 ^ {56'h0, 4'hF - j, j};
    x0 = x0 ^ x4;
    x4 = x4 ^ x3;
    x2 = x2 ^ x1;
    t0 = ~x0 & x1;
    t1 = ~x1 & x2;
    t2 = ~x2 & x3;
    t3 = ~x3 & x4;
    t4 = ~x4 & x0;
    x0 = x0 ^ t1;
    x1 = x1 ^ t2;
    x2 = x2 ^ t3;
    x3 = x3 ^ t4;
    x4 = x4 ^ t0;
    x1 = x1 ^ x0;
    x0 = x0 ^ x4;
    x3 = x3 ^ x2;
    x2 = ~x2;
    return {x0 ^ ror(x0, 19) ^ ror(x0, 28),
            x1 ^ ror(x1, 61) ^ ror(x1, 39),
            x2 ^ ror(x2, 1)  ^ ror(x2, 6),
            x3 ^ ror(x3, 10) ^ ror(x3, 17),
            x4 ^ ror(x4, 7)  ^ ror(x4, 41)};
  endfunction
  always_comb begin
    w_next = r_s;
    for (int g = 0; g < UNROLL; g++) w_next = round_f(w_next, r_j + 4'(g));
    w_last     = r_j == J_LAST;
    w_j_sum    = {1'b0, r_j} + 5'(UNROLL);
    w_j_next   = w_j_sum > 5'd11 ? 4'd11 : w_j_sum[3:0];
    w_fsm_next = r_fsm == IDLE ? (start_i ? RUN : IDLE) :
                 r_fsm == RUN  ? (w_last ? DONE : RUN) : IDLE;
  end
  always_ff @(posedge clock_i) begin
    if (resetb_i) begin
      r_fsm <= IDLE;
      r_j   <= '0;
      r_key <= '0;
      r_s   <= '0;
    end else begin
      r_fsm <= w_fsm_next;
      if (r_fsm == IDLE && start_i) begin
        r_j   <= J0;
        r_key <= key_i;
        r_s   <= {IV, key_i, nonce_i};
      end else if (r_fsm == RUN) begin
        r_j <= w_j_next;
        r_s <= w_last ? w_next ^ {192'h0, r_key} : w_next;
      end else if (r_fsm == DONE) begin
        r_j <= '0;
      end
    end
  end
  assign busy_o  = r_fsm != IDLE;
  assign end_o   = r_fsm == DONE;
  assign round_o = r_fsm == RUN ? r_j : 4'd0;
  assign state_o = r_s;
endmodule

// File: tb/tb_ascon_init_core.sv
// tb_ascon_init_core: directed vectors against a table-based ASCON reference,
// run on default, UNROLL=4, UNROLL=3 and ASCON-128a builds side by side.
module tb_ascon_init_core;
  logic clk = 0;
  always #5 clk = ~clk;
  logic         rst = 1, start = 0;
  logic [127:0] key = '0, nonce = '0;
  logic [3:0]   busy, endp;
  logic [3:0]   rnd [4];
  logic [319:0] st [4];
  int n_vec = 0, n_err = 0;
  int end_cyc [4] = '{13, 4, 5, 13};
  localparam logic [63:0] IV_DEF = 64'h80400c0600000000;
  localparam logic [63:0] IV_A   = 64'h80800c0800000000;
  logic [4:0] sbox [32] = '{5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
                            5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
                            5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
                            5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};
  typedef struct {
    logic [127:0] k;
    logic [127:0] n;
    logic [319:0] e_def;
    logic [319:0] e_a;
  } vec_t;
  vec_t tv [3];

  ascon_init_core u_dut (.clock_i(clk), .resetb_i(rst), .start_i(start), .key_i(key), .nonce_i(nonce),
    .busy_o(busy[0]), .end_o(endp[0]), .round_o(rnd[0]), .state_o(st[0]));
  ascon_init_core #(.UNROLL(4)) u_u4 (.clock_i(clk), .resetb_i(rst), .start_i(start), .key_i(key), .nonce_i(nonce),
    .busy_o(busy[1]), .end_o(endp[1]), .round_o(rnd[1]), .state_o(st[1]));
  ascon_init_core #(.UNROLL(3)) u_u3 (.clock_i(clk), .resetb_i(rst), .start_i(start), .key_i(key), .nonce_i(nonce),
    .busy_o(busy[2]), .end_o(endp[2]), .round_o(rnd[2]), .state_o(st[2]));
  ascon_init_core #(.RATE_BITS(128), .ROUNDS_B(8)) u_a (.clock_i(clk), .resetb_i(rst), .start_i(start), .key_i(key),
    .nonce_i(nonce), .busy_o(busy[3]), .end_o(endp[3]), .round_o(rnd[3]), .state_o(st[3]));

  function automatic logic [63:0] rr(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction
  // Reference p12 using the 5-bit S-box lookup table column by column.
  function automatic logic [319:0] ref_init(input logic [63:0] iv, input logic [127:0] k, input logic [127:0] n);
    logic [63:0] x [5];
    logic [63:0] y [5];
    logic [4:0]  v;
    x[0] = iv;
    x[1] = k[127:64];
    x[2] = k[63:0];
    x[3] = n[127:64];
    x[4] = n[63:0];
    for (int r = 0; r < 12; r++) begin
      x[2][7:0] = x[2][7:0] ^ {4'(15 - r), 4'(r)};
      for (int b = 0; b < 64; b++) begin
        v = sbox[{x[0][b], x[1][b], x[2][b], x[3][b], x[4][b]}];
        for (int i = 0; i < 5; i++) y[i][b] = v[4 - i];
      end
      x[0] = y[0] ^ rr(y[0], 19) ^ rr(y[0], 28);
      x[1] = y[1] ^ rr(y[1], 61) ^ rr(y[1], 39);
      x[2] = y[2] ^ rr(y[2], 1) ^ rr(y[2], 6);
      x[3] = y[3] ^ rr(y[3], 10) ^ rr(y[3], 17);
      x[4] = y[4] ^ rr(y[4], 7) ^ rr(y[4], 41);
    end
    return {x[0], x[1], x[2], x[3] ^ k[127:64], x[4] ^ k[63:0]};
  endfunction

  task automatic chk(input string name, input logic [319:0] act, input logic [319:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask
  task automatic chki(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask

  task automatic run_vec(input int i);
    int ec [4];
    int en [4];
    int drop;
    @(negedge clk);
    start = 1;
    key   = tv[i].k;
    nonce = tv[i].n;
    @(negedge clk);
    chk($sformatf("v%0d load_state", i), st[0], {IV_DEF, tv[i].k, tv[i].n});
    chk($sformatf("v%0d load_iv_a", i), {256'h0, st[3][319:256]}, {256'h0, IV_A});
    chki($sformatf("v%0d load_round", i), int'(rnd[0]), 0);
    start = 0;
    key   = ~key;
    nonce = {nonce[63:0], nonce[127:64]} ^ 128'h1;
    for (int q = 0; q < 4; q++) begin
      ec[q] = 0;
      en[q] = 0;
    end
    drop = 0;
    for (int c = 1; c <= 20; c++) begin
      for (int q = 0; q < 4; q++) if (endp[q]) begin
        en[q]++;
        if (ec[q] == 0) ec[q] = c;
      end
      if (c <= 13 && !busy[0]) drop++;
      if (c < 20) @(negedge clk);
    end
    for (int q = 0; q < 4; q++) begin
      chki($sformatf("v%0d end_cycle[%0d]", i, q), ec[q], end_cyc[q]);
      chki($sformatf("v%0d end_pulses[%0d]", i, q), en[q], 1);
      chk($sformatf("v%0d state[%0d]", i, q), st[q], q == 3 ? tv[i].e_a : tv[i].e_def);
    end
    chki($sformatf("v%0d busy_drop", i), drop, 0);
    chki($sformatf("v%0d idle_busy", i), int'(busy), 0);
  endtask

  initial begin
    int at [4];
    int na, lows, ends;
    logic prev;
    tv[0].k = 128'h8a55114d1cb6a9a2be263d4d7aecaaff;
    tv[0].n = 128'h4ed0ec0b98c529b7c8cddf37bcd0284a;
    tv[1].k = '0;
    tv[1].n = '0;
    tv[2].k = 128'h000102030405060708090a0b0c0d0e0f;
    tv[2].n = 128'hf0e1d2c3b4a5968778695a4b3c2d1e0f;
    for (int i = 0; i < 3; i++) begin
      tv[i].e_def = ref_init(IV_DEF, tv[i].k, tv[i].n);
      tv[i].e_a   = ref_init(IV_A, tv[i].k, tv[i].n);
    end
    repeat (2) @(negedge clk);
    rst = 0;
    chki("reset busy", int'(busy[0]), 0);
    chki("reset end", int'(endp[0]), 0);
    chki("reset round", int'(rnd[0]), 0);
    chk("reset state", st[0], '0);
    for (int i = 0; i < 3; i++) run_vec(i);
    // start held high: DONE-cycle start ignored, next IDLE start accepted
    @(negedge clk);
    start = 1;
    key   = tv[0].k;
    nonce = tv[0].n;
    na = 0;
    lows = 0;
    prev = busy[0];
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (busy[0] && !prev && na < 4) begin
        at[na] = c;
        na++;
      end
      if (!busy[0]) lows++;
      prev = busy[0];
    end
    start = 0;
    chki("held accepts", na, 4);
    chki("held gap1", at[1] - at[0], 14);
    chki("held gap2", at[2] - at[1], 14);
    chki("held idle_cycles", lows, 3);
    repeat (20) @(negedge clk);
    chk("held state", st[0], tv[0].e_def);
    // reset in cycle 5 of RUN aborts without an end pulse
    start = 1;
    key   = tv[2].k;
    nonce = tv[2].n;
    @(negedge clk);
    start = 0;
    repeat (4) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chki("abort busy", int'(busy[0]), 0);
    chki("abort round", int'(rnd[0]), 0);
    chk("abort state", st[0], '0);
    chk("abort state_a", st[3], '0);
    ends = 0;
    for (int c = 0; c < 20; c++) begin
      if (endp[0] || endp[3]) ends++;
      @(negedge clk);
    end
    chki("abort end_pulses", ends, 0);
    run_vec(2);
    // reset wins over start in IDLE
    @(negedge clk);
    rst   = 1;
    start = 1;
    @(negedge clk);
    chki("rst+start busy", int'(busy[0]), 0);
    rst   = 0;
    start = 0;
    @(negedge clk);
    chki("rst+start idle", int'(busy[0]), 0);
    chk("rst+start state", st[0], '0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
